// File: rtl/regfile32.sv
// 32 x WIDTH register file with two combinational read ports, written through a one-hot
// select word from the address decoder. r0 has no storage and always reads as zero.
module regfile32 #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             sel_err
);

    logic [WIDTH-1:0] regs_q [1:31];
    logic [WIDTH-1:0] rf_view [32];
    logic             sel_err_q;
    logic             multi_hot;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot = |(wr_sel & (wr_sel - 32'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
            if (multi_hot) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rf_view[i] = regs_q[i];
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != 5'd0) begin
            if (BYPASS && wr_sel[rd_addr1]) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = rf_view[rd_addr1];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rd_addr2 != 5'd0) begin
            if (BYPASS && wr_sel[rd_addr2]) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = rf_view[rd_addr2];
            end
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile32.sv
// Directed bench for regfile32: one BYPASS=0 and one BYPASS=1 instance share all inputs.
module tb_regfile32;

    logic        clk;
    logic        reset;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd0_data1, rd0_data2, rd1_data1, rd1_data2;
    logic        err0, err1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    regfile32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd0_data1),
        .rd_data2 (rd0_data2),
        .sel_err  (err0)
    );

    regfile32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd1_data1),
        .rd_data2 (rd1_data2),
        .sel_err  (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read both ports of both instances; use only where BYPASS cannot matter.
    task automatic read_both(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
        check({tag, " b0 p1"}, rd0_data1, e1);
        check({tag, " b0 p2"}, rd0_data2, e2);
        check({tag, " b1 p1"}, rd1_data1, e1);
        check({tag, " b1 p2"}, rd1_data2, e2);
    endtask

    initial begin
        logic [31:0] pat;

        reset    = 1'b1;
        wr_sel   = 32'h0;
        wr_data  = 32'h0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        tick();
        reset = 1'b0;

        // Post-reset sweep: everything reads zero, no error flag.
        for (int a = 0; a < 32; a++) begin
            read_both("reset sweep", 5'(a), 5'(31 - a), 32'h0, 32'h0);
        end
        check("reset sel_err b0", {31'h0, err0}, 32'h0);
        check("reset sel_err b1", {31'h0, err1}, 32'h0);

        // Single write to r1.
        wr_sel  = 32'h0000_0002;
        wr_data = 32'hDEAD_BEEF;
        tick();
        wr_sel = 32'h0;
        read_both("write r1", 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0);

        // Write to r0 is ignored and is not an error.
        wr_sel  = 32'h0000_0001;
        wr_data = 32'hFFFF_FFFF;
        rd_addr1 = 5'd0;
        #1;
        check("bypass r0 pre-edge", rd1_data1, 32'h0);
        tick();
        wr_sel = 32'h0;
        read_both("write r0", 5'd0, 5'd1, 32'h0, 32'hDEAD_BEEF);
        check("r0 sel_err", {31'h0, err0}, 32'h0);

        // Distinct pattern in every register, then read them all back.
        for (int i = 1; i < 32; i++) begin
            wr_sel  = 32'd1 << i;
            wr_data = 32'(i) * 32'h0101_0101;
            tick();
        end
        wr_sel = 32'h0;
        for (int i = 1; i < 32; i++) begin
            pat = 32'(i) * 32'h0101_0101;
            read_both("pattern", 5'(i), 5'(i), pat, pat);
        end
        read_both("pattern r31/r0", 5'd31, 5'd0, 32'h1F1F_1F1F, 32'h0);

        // Same-cycle read of the register being written.
        wr_sel  = 32'h0000_0400;
        wr_data = 32'h0000_0005;
        tick();
        wr_sel  = 32'h0000_0400;
        wr_data = 32'h1234_5678;
        rd_addr1 = 5'd10;
        rd_addr2 = 5'd10;
        #1;
        check("same-cycle b0 p1", rd0_data1, 32'h0000_0005);
        check("same-cycle b0 p2", rd0_data2, 32'h0000_0005);
        check("same-cycle b1 p1", rd1_data1, 32'h1234_5678);
        check("same-cycle b1 p2", rd1_data2, 32'h1234_5678);
        tick();
        wr_sel = 32'h0;
        read_both("after edge r10", 5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678);
        check("clean sel_err", {31'h0, err0}, 32'h0);

        // Bit 0 plus one other bit is multi-hot.
        wr_sel  = 32'h0000_0003;
        wr_data = 32'h0BAD_F00D;
        tick();
        wr_sel = 32'h0;
        read_both("bit0+r1", 5'd1, 5'd0, 32'h0BAD_F00D, 32'h0);
        check("bit0+r1 sel_err b0", {31'h0, err0}, 32'h1);
        check("bit0+r1 sel_err b1", {31'h0, err1}, 32'h1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset clears sel_err", {31'h0, err0}, 32'h0);

        // Multi-hot write to r1 and r2.
        wr_sel  = 32'h0000_0006;
        wr_data = 32'hA5A5_A5A5;
        tick();
        wr_sel = 32'h0;
        read_both("multi-hot", 5'd1, 5'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        read_both("multi-hot r3", 5'd3, 5'd10, 32'h0, 32'h0);
        check("multi-hot sel_err b0", {31'h0, err0}, 32'h1);
        check("multi-hot sel_err b1", {31'h0, err1}, 32'h1);
        tick();
        check("sel_err sticky", {31'h0, err0}, 32'h1);

        // Reset wins over a simultaneous write.
        reset   = 1'b1;
        wr_sel  = 32'h0000_0008;
        wr_data = 32'h0000_0077;
        tick();
        reset  = 1'b0;
        wr_sel = 32'h0;
        read_both("reset drop r3", 5'd3, 5'd1, 32'h0, 32'h0);
        read_both("reset r2/r31", 5'd2, 5'd31, 32'h0, 32'h0);
        check("reset sel_err b0 final", {31'h0, err0}, 32'h0);
        check("reset sel_err b1 final", {31'h0, err1}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
